// File: rtl/qam_tx_sequencer.sv
// Frames buffered 4-bit symbols into preamble, payload and zero tail for the 16-QAM modulator.
// Latency: start sampled at edge N puts the first preamble symbol on din in cycle N+1.
// Backpressure: din/din_valid hold while din_ready is low; s_ready drops while the payload FIFO is full.
module qam_tx_sequencer #(
  parameter int PREAMBLE_LEN = 16,
  parameter int PAYLOAD_LEN  = 128,
  parameter int TAIL_LEN     = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          axi_clk,
  input  logic                          axi_rstn,
  input  logic                          start,
  input  logic                          s_valid,
  input  logic [3:0]                    s_data,
  output logic                          s_ready,
  output logic                          din_valid,
  output logic [3:0]                    din,
  input  logic                          din_ready,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int TOTAL = PREAMBLE_LEN + PAYLOAD_LEN + TAIL_LEN;
  localparam int CW    = $clog2(TOTAL + 1);

  // Load-index boundaries: ld_idx counts symbols already placed in the output register this frame.
  localparam logic [CW-1:0] PAY_FIRST  = CW'(PREAMBLE_LEN);
  localparam logic [CW-1:0] TAIL_FIRST = CW'(PREAMBLE_LEN + PAYLOAD_LEN);
  localparam logic [CW-1:0] LD_END     = CW'(TOTAL);
  // Transfer-count values that close each phase.
  localparam logic [CW-1:0] PRE_LAST   = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST   = CW'(PAYLOAD_LEN - 1);
  localparam logic [CW-1:0] TAIL_LAST  = CW'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
  localparam logic [LW-1:0] DEPTH_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRE, PAY, TAIL} state_t;

  state_t        state;
  logic [CW-1:0] sym_cnt;
  logic [CW-1:0] ld_idx;
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          ready_en;
  logic [3:0]    fifo_head;
  logic          wr_fire;
  logic          xfer;
  logic          load_en;
  logic          ld_more;
  logic          ld_pre;
  logic          ld_pay;
  logic          fifo_nempty;
  logic          pop;
  logic          phase_last;

  // s_ready is held low while in reset and for the first edge after release.
  assign s_ready     = ready_en && (fifo_level < DEPTH_LVL);
  assign wr_fire     = s_valid && s_ready;
  assign xfer        = din_valid && din_ready;
  // The output register refills whenever it is empty or its current symbol leaves this edge.
  assign load_en     = (state != IDLE) && (!din_valid || din_ready);
  assign ld_more     = ld_idx < LD_END;
  assign ld_pre      = ld_idx < PAY_FIRST;
  assign ld_pay      = !ld_pre && (ld_idx < TAIL_FIRST);
  assign fifo_nempty = (fifo_level != '0);
  // Payload slots stop popping once all PAYLOAD_LEN symbols have been loaded.
  assign pop         = load_en && ld_pay && fifo_nempty;
  assign fifo_head   = fifo_mem[rd_ptr];
  assign busy        = (state != IDLE);

  // Decide whether the current transfer closes the active phase.
  always_comb begin
    phase_last = 1'b0;
    case (state)
      PRE:     phase_last = (sym_cnt == PRE_LAST);
      PAY:     phase_last = (sym_cnt == PAY_LAST);
      TAIL:    phase_last = (sym_cnt == TAIL_LAST);
      default: phase_last = 1'b0;
    endcase
  end

  // Enable upstream acceptance one edge after reset release.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Payload storage; contents are don't-care until the pointers make them valid.
  always_ff @(posedge axi_clk) begin
    if (wr_fire) begin
      fifo_mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_fire, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Frame sequencer: phase tracking, output symbol register and status flags.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      ld_idx     <= '0;
      din_valid  <= 1'b0;
      din        <= 4'h0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state     <= PRE;
          sym_cnt   <= '0;
          ld_idx    <= CW'(1);
          din_valid <= 1'b1;
          din       <= 4'h0;
          underrun  <= 1'b0;
        end
      end else begin
        if (load_en) begin
          if (!ld_more) begin
            din_valid <= 1'b0;
          end else if (ld_pay) begin
            if (fifo_nempty) begin
              din       <= fifo_head;
              din_valid <= 1'b1;
              ld_idx    <= ld_idx + 1'b1;
            end else begin
              // Starved: leave a bubble and retry next cycle without advancing the count.
              din_valid <= 1'b0;
              underrun  <= 1'b1;
            end
          end else begin
            din       <= (ld_pre && ld_idx[0]) ? 4'hF : 4'h0;
            din_valid <= 1'b1;
            ld_idx    <= ld_idx + 1'b1;
          end
        end
        if (xfer) begin
          if (phase_last) begin
            sym_cnt <= '0;
            case (state)
              PRE: state <= PAY;
              PAY: begin
                if (TAIL_LEN > 0) begin
                  state <= TAIL;
                end else begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
                end
              end
              TAIL: begin
                state      <= IDLE;
                frame_done <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end else begin
            sym_cnt <= sym_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_tx_sequencer.sv
`timescale 1ns/1ps
module tb_qam_tx_sequencer;

  localparam int P   = 4;
  localparam int Y   = 8;
  localparam int T   = 2;
  localparam int D   = 4;
  localparam int N   = P + Y + T;
  localparam int LW  = $clog2(D) + 1;
  localparam int DP  = 16;
  localparam int DY  = 128;
  localparam int DT  = 8;
  localparam int DD  = 16;
  localparam int DN  = DP + DY + DT;
  localparam int DLW = $clog2(DD) + 1;

  logic axi_clk = 1'b0;
  logic axi_rstn = 1'b0;
  always #5 axi_clk = ~axi_clk;

  logic          start, s_valid, s_ready, din_valid, din_ready, busy, frame_done, underrun;
  logic [3:0]    s_data, din;
  logic [LW-1:0] fifo_level;

  logic           start_d, s_valid_d, s_ready_d, din_valid_d, din_ready_d, busy_d, frame_done_d, underrun_d;
  logic [3:0]     s_data_d, din_d;
  logic [DLW-1:0] fifo_level_d;

  qam_tx_sequencer #(.PREAMBLE_LEN(P), .PAYLOAD_LEN(Y), .TAIL_LEN(T), .FIFO_DEPTH(D)) dut (
    .axi_clk(axi_clk), .axi_rstn(axi_rstn), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .busy(busy), .frame_done(frame_done), .underrun(underrun), .fifo_level(fifo_level)
  );

  qam_tx_sequencer dut_d (
    .axi_clk(axi_clk), .axi_rstn(axi_rstn), .start(start_d),
    .s_valid(s_valid_d), .s_data(s_data_d), .s_ready(s_ready_d),
    .din_valid(din_valid_d), .din(din_d), .din_ready(din_ready_d),
    .busy(busy_d), .frame_done(frame_done_d), .underrun(underrun_d), .fifo_level(fifo_level_d)
  );

  int cmp_n = 0;
  int bad_n = 0;
  int cyc = 0;
  always @(posedge axi_clk) cyc <= cyc + 1;

  logic [3:0] feed_q[$];
  logic [3:0] got_q[$];
  int         got_cyc[$];
  int         done_cyc[$];
  int         done_bad;
  int         hold_bad;
  int         rdy_mode;
  logic       prev_dv, prev_dr;
  logic [3:0] prev_din;

  logic       feed_d_en;
  logic [3:0] wr_d[$];
  logic [3:0] got_d[$];
  int         got_d_cyc[$];
  int         done_d_cyc[$];
  int         hold_bad_d;
  logic       prev_dv_d, prev_dr_d;
  logic [3:0] prev_din_d;

  // Observe the small instance at the falling edge: a handshake seen here completes on the next rising edge.
  always @(negedge axi_clk) begin
    if (s_valid && s_ready && feed_q.size() > 0) feed_q.delete(0);
    if (din_valid && din_ready) begin
      got_q.push_back(din);
      got_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cyc.push_back(cyc);
      if (busy || din_valid) done_bad++;
    end
    if (axi_rstn && prev_dv && !prev_dr && !(din_valid && din == prev_din)) hold_bad++;
    prev_dv  = din_valid;
    prev_dr  = din_ready;
    prev_din = din;
  end

  // Observe the default-parameter instance the same way.
  always @(negedge axi_clk) begin
    if (s_valid_d && s_ready_d) wr_d.push_back(s_data_d);
    if (din_valid_d && din_ready_d) begin
      got_d.push_back(din_d);
      got_d_cyc.push_back(cyc);
    end
    if (frame_done_d) done_d_cyc.push_back(cyc);
    if (axi_rstn && prev_dv_d && !prev_dr_d && !(din_valid_d && din_d == prev_din_d)) hold_bad_d++;
    prev_dv_d  = din_valid_d;
    prev_dr_d  = din_ready_d;
    prev_din_d = din_d;
  end

  // Background drivers for upstream data and modulator ready.
  initial begin
    s_valid = 1'b0; s_data = 4'h0; din_ready = 1'b0;
    s_valid_d = 1'b0; s_data_d = 4'h0;
    forever begin
      @(posedge axi_clk);
      #2;
      if (feed_q.size() > 0) begin
        s_valid = 1'b1;
        s_data  = feed_q[0];
      end else begin
        s_valid = 1'b0;
        s_data  = 4'h0;
      end
      case (rdy_mode)
        0:       din_ready = 1'b1;
        1:       din_ready = ($urandom_range(0, 3) != 0);
        default: din_ready = 1'b0;
      endcase
      s_valid_d = feed_d_en;
      s_data_d  = 4'($urandom_range(0, 15));
    end
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  function automatic logic [3:0] pre_sym(int k);
    return (k % 2 == 1) ? 4'hF : 4'h0;
  endfunction

  task automatic clear_obs();
    got_q.delete(); got_cyc.delete(); done_cyc.delete();
    done_bad = 0; hold_bad = 0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done_cyc.size() == 0 && k < budget) begin tick(); k++; end
    cmp_n++; if (done_cyc.size() == 0) begin bad_n++; $display("FAIL %s_timeout: no frame_done within %0d cycles", tag, budget); end
  endtask

  task automatic test_reset();
    start = 1'b0; start_d = 1'b0; din_ready_d = 1'b0; feed_d_en = 1'b0; rdy_mode = 2;
    axi_rstn = 1'b0;
    repeat (3) tick();
    cmp_n++; if (din_valid !== 1'b0)   begin bad_n++; $display("FAIL rst_din_valid: got %b want 0", din_valid); end
    cmp_n++; if (din !== 4'h0)         begin bad_n++; $display("FAIL rst_din: got %h want 0", din); end
    cmp_n++; if (busy !== 1'b0)        begin bad_n++; $display("FAIL rst_busy: got %b want 0", busy); end
    cmp_n++; if (frame_done !== 1'b0)  begin bad_n++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    cmp_n++; if (underrun !== 1'b0)    begin bad_n++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    cmp_n++; if (fifo_level !== '0)    begin bad_n++; $display("FAIL rst_fifo_level: got %0d want 0", fifo_level); end
    cmp_n++; if (s_ready !== 1'b0)     begin bad_n++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    cmp_n++; if (din_valid_d !== 1'b0) begin bad_n++; $display("FAIL rst_din_valid_d: got %b want 0", din_valid_d); end
    axi_rstn = 1'b1;
    tick(); tick();
    cmp_n++; if (s_ready !== 1'b1)     begin bad_n++; $display("FAIL rst_s_ready_after: got %b want 1", s_ready); end
    cmp_n++; if (busy !== 1'b0)        begin bad_n++; $display("FAIL rst_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_fifo_full();
    for (int v = 1; v <= 4; v++) feed_q.push_back(4'(v));
    feed_q.push_back(4'h9);
    for (int k = 1; k <= 4; k++) begin
      tick();
      cmp_n++; if (fifo_level !== LW'(k)) begin bad_n++; $display("FAIL full_level_%0d: got %0d want %0d", k, fifo_level, k); end
      cmp_n++; if (s_ready !== (k < 4))   begin bad_n++; $display("FAIL full_s_ready_%0d: got %b want %b", k, s_ready, (k < 4)); end
    end
    tick(); tick();
    cmp_n++; if (fifo_level !== LW'(4)) begin bad_n++; $display("FAIL full_level_hold: got %0d want 4", fifo_level); end
    cmp_n++; if (feed_q.size() != 1)    begin bad_n++; $display("FAIL full_fifth_rejected: pending %0d want 1", feed_q.size()); end
    feed_q.delete();
    tick();
  endtask

  task automatic test_full_frame();
    logic [3:0] exp[$];
    int s_cyc;
    clear_obs(); rdy_mode = 0;
    for (int v = 5; v <= 8; v++) feed_q.push_back(4'(v));
    for (int i = 0; i < P; i++) exp.push_back(pre_sym(i));
    for (int v = 1; v <= Y; v++) exp.push_back(4'(v));
    for (int i = 0; i < T; i++) exp.push_back(4'h0);
    start = 1'b1; s_cyc = cyc + 1; tick(); start = 1'b0;
    cmp_n++; if (busy !== 1'b1 || din_valid !== 1'b1 || din !== 4'h0) begin bad_n++; $display("FAIL ff_latency: busy %b dv %b din %h want 1 1 0", busy, din_valid, din); end
    wait_done(100, "ff");
    cmp_n++; if (got_q.size() != N) begin bad_n++; $display("FAIL ff_count: got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      cmp_n++; if (got_q[i] !== exp[i])     begin bad_n++; $display("FAIL ff_sym_%0d: got %h want %h", i, got_q[i], exp[i]); end
      cmp_n++; if (got_cyc[i] != s_cyc + i) begin bad_n++; $display("FAIL ff_cycle_%0d: got %0d want %0d", i, got_cyc[i], s_cyc + i); end
    end
    if (done_cyc.size() > 0) begin
      cmp_n++; if (done_cyc[0] != s_cyc + N) begin bad_n++; $display("FAIL ff_done_cycle: got %0d want %0d", done_cyc[0], s_cyc + N); end
    end
    cmp_n++; if (done_bad != 0)   begin bad_n++; $display("FAIL ff_done_idle: busy/din_valid high in done cycle %0d times want 0", done_bad); end
    cmp_n++; if (underrun !== 1'b0) begin bad_n++; $display("FAIL ff_underrun: got %b want 0", underrun); end
    tick(); tick();
    cmp_n++; if (done_cyc.size() != 1) begin bad_n++; $display("FAIL ff_done_pulses: got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_underrun();
    logic [3:0] pay[$];
    logic [3:0] exp[$];
    int k;
    clear_obs(); rdy_mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (got_q.size() < P && k < 50) begin tick(); k++; end
    cmp_n++; if (din_valid !== 1'b0 || underrun !== 1'b1 || busy !== 1'b1) begin bad_n++; $display("FAIL ur_entry: dv %b underrun %b busy %b want 0 1 1", din_valid, underrun, busy); end
    for (int c = 0; c < 4; c++) begin
      tick();
      cmp_n++; if (din_valid !== 1'b0) begin bad_n++; $display("FAIL ur_bubble_%0d: din_valid %b want 0", c, din_valid); end
    end
    for (int i = 0; i < Y; i++) begin
      pay.push_back(4'($urandom_range(0, 15)));
      feed_q.push_back(pay[i]);
    end
    wait_done(200, "ur");
    for (int i = 0; i < P; i++) exp.push_back(pre_sym(i));
    for (int i = 0; i < Y; i++) exp.push_back(pay[i]);
    for (int i = 0; i < T; i++) exp.push_back(4'h0);
    cmp_n++; if (got_q.size() != N) begin bad_n++; $display("FAIL ur_count: got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      cmp_n++; if (got_q[i] !== exp[i]) begin bad_n++; $display("FAIL ur_sym_%0d: got %h want %h", i, got_q[i], exp[i]); end
    end
    tick(); tick(); tick();
    cmp_n++; if (underrun !== 1'b1)    begin bad_n++; $display("FAIL ur_sticky: got %b want 1", underrun); end
    cmp_n++; if (done_cyc.size() != 1) begin bad_n++; $display("FAIL ur_done_pulses: got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_ignored_start();
    logic [3:0] pay[$];
    logic [3:0] exp[$];
    int k;
    clear_obs(); rdy_mode = 1;
    for (int i = 0; i < Y; i++) begin
      pay.push_back(4'($urandom_range(0, 15)));
      feed_q.push_back(pay[i]);
    end
    repeat (8) tick();
    cmp_n++; if (fifo_level !== LW'(D)) begin bad_n++; $display("FAIL is_preload: level %0d want %0d", fifo_level, D); end
    start = 1'b1; tick(); start = 1'b0;
    cmp_n++; if (underrun !== 1'b0 || busy !== 1'b1) begin bad_n++; $display("FAIL is_start_clears: underrun %b busy %b want 0 1", underrun, busy); end
    k = 0;
    while (got_q.size() < P + 2 && k < 200) begin tick(); k++; end
    start = 1'b1; tick(); start = 1'b0;
    wait_done(400, "is");
    tick(); tick(); tick();
    for (int i = 0; i < P; i++) exp.push_back(pre_sym(i));
    for (int i = 0; i < Y; i++) exp.push_back(pay[i]);
    for (int i = 0; i < T; i++) exp.push_back(4'h0);
    cmp_n++; if (got_q.size() != N) begin bad_n++; $display("FAIL is_count: got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      cmp_n++; if (got_q[i] !== exp[i]) begin bad_n++; $display("FAIL is_sym_%0d: got %h want %h", i, got_q[i], exp[i]); end
    end
    cmp_n++; if (done_cyc.size() != 1) begin bad_n++; $display("FAIL is_done_pulses: got %0d want 1", done_cyc.size()); end
    cmp_n++; if (hold_bad != 0)        begin bad_n++; $display("FAIL is_hold: din changed while stalled %0d times want 0", hold_bad); end
    cmp_n++; if (underrun !== 1'b0)    begin bad_n++; $display("FAIL is_underrun: got %b want 0", underrun); end
    cmp_n++; if (busy !== 1'b0)        begin bad_n++; $display("FAIL is_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] pay[$];
    logic [3:0] exp[$];
    int k, s_cyc;
    clear_obs(); rdy_mode = 0;
    for (int i = 0; i < D; i++) feed_q.push_back(4'($urandom_range(0, 15)));
    repeat (6) tick();
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (got_q.size() < P && k < 50) begin tick(); k++; end
    cmp_n++; if (fifo_level !== LW'(3) || busy !== 1'b1) begin bad_n++; $display("FAIL rm_pre: level %0d busy %b want 3 1", fifo_level, busy); end
    #1 axi_rstn = 1'b0;
    #1;
    cmp_n++; if (din_valid !== 1'b0)   begin bad_n++; $display("FAIL rm_din_valid: got %b want 0", din_valid); end
    cmp_n++; if (busy !== 1'b0)        begin bad_n++; $display("FAIL rm_busy: got %b want 0", busy); end
    cmp_n++; if (fifo_level !== '0)    begin bad_n++; $display("FAIL rm_level: got %0d want 0", fifo_level); end
    cmp_n++; if (s_ready !== 1'b0)     begin bad_n++; $display("FAIL rm_s_ready: got %b want 0", s_ready); end
    tick(); tick();
    axi_rstn = 1'b1;
    feed_q.delete();
    tick(); tick();
    clear_obs();
    for (int i = 0; i < Y; i++) begin
      pay.push_back(4'($urandom_range(0, 15)));
      feed_q.push_back(pay[i]);
    end
    repeat (6) tick();
    start = 1'b1; s_cyc = cyc + 1; tick(); start = 1'b0;
    wait_done(200, "rm");
    for (int i = 0; i < P; i++) exp.push_back(pre_sym(i));
    for (int i = 0; i < Y; i++) exp.push_back(pay[i]);
    for (int i = 0; i < T; i++) exp.push_back(4'h0);
    cmp_n++; if (got_q.size() != N) begin bad_n++; $display("FAIL rm_count: got %0d want %0d", got_q.size(), N); end
    if (got_cyc.size() > 0) begin
      cmp_n++; if (got_cyc[0] != s_cyc) begin bad_n++; $display("FAIL rm_first_cycle: got %0d want %0d", got_cyc[0], s_cyc); end
    end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      cmp_n++; if (got_q[i] !== exp[i]) begin bad_n++; $display("FAIL rm_sym_%0d: got %h want %h", i, got_q[i], exp[i]); end
    end
  endtask

  task automatic test_pacing();
    logic [3:0] exp[$];
    int k;
    got_d.delete(); got_d_cyc.delete(); done_d_cyc.delete(); wr_d.delete();
    hold_bad_d = 0; din_ready_d = 1'b0;
    feed_d_en = 1'b1;
    repeat (DD + 4) tick();
    cmp_n++; if (fifo_level_d !== DLW'(DD) || s_ready_d !== 1'b0) begin bad_n++; $display("FAIL pc_fill: level %0d s_ready %b want %0d 0", fifo_level_d, s_ready_d, DD); end
    start_d = 1'b1; tick(); start_d = 1'b0;
    k = 0;
    while (done_d_cyc.size() == 0 && k < 2000) begin
      din_ready_d = (k % 8 == 7);
      tick(); k++;
    end
    din_ready_d = 1'b0; feed_d_en = 1'b0;
    cmp_n++; if (done_d_cyc.size() == 0) begin bad_n++; $display("FAIL pc_timeout: no frame_done within 2000 cycles"); end
    for (int i = 0; i < DP; i++) exp.push_back(pre_sym(i));
    for (int i = 0; i < DY && i < wr_d.size(); i++) exp.push_back(wr_d[i]);
    for (int i = 0; i < DT; i++) exp.push_back(4'h0);
    cmp_n++; if (got_d.size() != DN) begin bad_n++; $display("FAIL pc_count: got %0d want %0d", got_d.size(), DN); end
    for (int i = 0; i < DN && i < got_d.size() && i < exp.size(); i++) begin
      cmp_n++; if (got_d[i] !== exp[i]) begin bad_n++; $display("FAIL pc_sym_%0d: got %h want %h", i, got_d[i], exp[i]); end
    end
    if (done_d_cyc.size() > 0 && got_d_cyc.size() > 0) begin
      cmp_n++; if (done_d_cyc[0] != got_d_cyc[got_d_cyc.size()-1] + 1) begin bad_n++; $display("FAIL pc_done_cycle: got %0d want %0d", done_d_cyc[0], got_d_cyc[got_d_cyc.size()-1] + 1); end
    end
    cmp_n++; if (hold_bad_d != 0) begin bad_n++; $display("FAIL pc_hold: din changed between pulses %0d times want 0", hold_bad_d); end
    tick(); tick();
    cmp_n++; if (done_d_cyc.size() != 1 || busy_d !== 1'b0) begin bad_n++; $display("FAIL pc_end: pulses %0d busy %b want 1 0", done_d_cyc.size(), busy_d); end
  endtask

  initial begin
    done_bad = 0; hold_bad = 0; hold_bad_d = 0;
    test_reset();
    test_fifo_full();
    test_full_frame();
    test_underrun();
    test_ignored_start();
    test_reset_mid_frame();
    test_pacing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule

// File: doc/qam_tx_sequencer.md
# qam_tx_sequencer

Frame sequencer in front of the 16-QAM modulator top. It buffers upstream 4-bit symbols in a small FIFO and, on `start`, drives the modulator's `din_valid`/`din`/`din_ready` port with a frame. Each frame is a fixed preamble, then exactly `PAYLOAD_LEN` buffered symbols, then `TAIL_LEN` zero symbols that flush the shaping filter. It reports busy/done/underrun status to the control plane.

## Interface
- `PREAMBLE_LEN`, 16, preamble symbols per frame (≥1).
- `PAYLOAD_LEN`, 128, payload symbols per frame (≥1).
- `TAIL_LEN`, 8, zero-valued flush symbols per frame (≥0).
- `FIFO_DEPTH`, 16, payload FIFO entries (power of 2, ≥2).
- `axi_clk` in 1: single clock, all logic rising-edge.
- `axi_rstn` in 1: asynchronous, active-low reset.
- `start` in 1: frame request; sampled only in IDLE.
- `s_valid` in 1: upstream symbol valid.
- `s_data` in 4: upstream symbol.
- `s_ready` out 1: FIFO not full.
- `din_valid` out 1: symbol valid to modulator (registered).
- `din` out 4: symbol to modulator (registered).
- `din_ready` in 1: modulator accepts symbol.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse at frame end.
- `underrun` out 1: sticky; payload symbol needed but FIFO empty; cleared on accepted `start`.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- States: IDLE, PRE, PAY, TAIL.
  - IDLE→PRE on `start`.
  - PRE→PAY after `PREAMBLE_LEN` accepted symbols.
  - PAY→TAIL after `PAYLOAD_LEN` accepted symbols.
  - TAIL→IDLE after `TAIL_LEN` accepted symbols, or directly PAY→IDLE if `TAIL_LEN`=0.
- Transfer: a symbol moves when `din_valid && din_ready` at a clock edge.
  - `din` is held stable while `din_valid && !din_ready`.
  - `din_valid` never drops without a transfer, except by reset.
- Symbol counter `sym_cnt` increments per transfer and clears on each state change.
- Preamble symbol k (0-based) = 4'h0 for even k, 4'hF for odd k.
- Tail symbols = 4'h0.
- FIFO:
  - Write when `s_valid && s_ready`; `s_ready` = `fifo_level < FIFO_DEPTH`.
  - The FIFO accepts writes in every state, including IDLE, so payload can be preloaded.
  - Simultaneous read and write leave `fifo_level` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Output register load: the register loads when it is empty (`!din_valid`) or transferring this cycle.
  - PRE and TAIL: loads the next pattern symbol.
  - PAY: pops the FIFO head if `fifo_level>0`; the pop is counted in `fifo_level` that cycle.
- Underrun in PAY: if a load is required but the FIFO is empty, `din_valid`=0 and `underrun` is set.
  - The frame does not abort. The next available symbol is loaded in a later cycle, and the payload count still completes at `PAYLOAD_LEN`.
- No over-read: after the last payload symbol is loaded, no further pops occur in that frame.
- `start` while `busy` is ignored, with no queuing.

## Timing
- Reset values: `din_valid`=0, `din`=0, `busy`=0, `frame_done`=0, `underrun`=0, `fifo_level`=0, `s_ready`=0 during reset then 1; state=IDLE, FIFO emptied.
- Latency: `start` at edge N gives `busy`=1 and `din_valid`=1 with `din`=4'h0 after edge N (visible in cycle N+1).
- Back-to-back: with `din_ready` held high, one symbol transfers every cycle. There are no bubbles at PRE→PAY or PAY→TAIL when the FIFO is non-empty.
- With the modulator's native upsampled `din_ready` (a 1-cycle pulse every 8 cycles), `din` is held across all 7 intervening cycles.
- FIFO write to `s_ready` deassert: `s_ready` deasserts in the cycle after the write that filled the FIFO.
- `frame_done` pulses in the cycle after the last tail transfer (or the last payload transfer if `TAIL_LEN`=0). In that same cycle `busy`=0 and `din_valid`=0.
- A `start` asserted during the `frame_done` cycle is accepted.
- Reset mid-frame (asynchronous `axi_rstn` low): all outputs take reset values immediately, FIFO contents are discarded, state=IDLE.

## Test plan
Directed tests use PREAMBLE_LEN=4, PAYLOAD_LEN=8, TAIL_LEN=2, FIFO_DEPTH=4 unless noted.
- **Preload + full frame, `din_ready`=1:**
  - Stimulus: write 4 symbols 1,2,3,4, then `start`; refill 5..8 as `s_ready` allows.
  - Response: `din` sequence 0,F,0,F,1,2,…,8,0,0 over 14 consecutive cycles; `frame_done` one cycle after the last 0; `underrun`=0.
- **FIFO full:**
  - Stimulus: write 5 symbols in IDLE.
  - Response: `s_ready`=0 after the 4th; the 5th is not accepted; `fifo_level`=4.
- **Modulator-rate pacing:**
  - Stimulus: `din_ready` pulses once every 8 cycles (default parameters, FIFO kept fed).
  - Response: `din` is stable between pulses; 16+128+8=152 transfers; `frame_done` after the 152nd.
- **Underrun:**
  - Stimulus: `start` with an empty FIFO; feed the first payload symbol 5 cycles after PAY entry.
  - Response: `din_valid`=0 for those cycles; `underrun`=1 and remains set; the frame still ends after 8 payload symbols; the next `start` clears `underrun`.
- **Ignored start:**
  - Stimulus: pulse `start` in PAY.
  - Response: no effect on sequence or count; exactly one `frame_done`.
- **Reset mid-frame:**
  - Stimulus: drop `axi_rstn` during PAY with `fifo_level`=3.
  - Response: `din_valid`=0, `busy`=0, `fifo_level`=0 immediately; after release, a new `start` begins with preamble symbol 0.
